// File: rtl/rs_pipe.sv
// rs_pipe: registered ShiftRows/InvShiftRows for Nb = 4, 6, 8 with a 2-entry skid FIFO.
// Optional RS_PIPE_STATS_EN adds blk_cnt_o, a wrapping count of popped blocks.
module rs_pipe #(
  parameter int NB = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        enc_dec_i,
  input  logic [31:0] state_i [NB-1:0],
  output logic        valid_o,
  input  logic        ready_i,
  output logic        enc_dec_o,
  output logic [31:0] state_o [NB-1:0]
`ifdef RS_PIPE_STATS_EN
  ,
  output logic [15:0] blk_cnt_o
`endif
);

  if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
    $error("rs_pipe: NB must be 4, 6 or 8");
  end

  localparam int C2 = (NB == 8) ? 3 : 2;
  localparam int C3 = (NB == 8) ? 4 : 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e state_q, state_d;

  logic [31:0] shf    [NB-1:0];
  logic [31:0] head_q [NB-1:0];
  logic [31:0] tail_q [NB-1:0];
  logic        head_enc_q;
  logic        tail_enc_q;

  logic ld_new;
  logic ld_tail;
  logic mv_tail;
  logic pop;

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SH = (r == 0) ? 0 :
                          (r == 1) ? 1 :
                          (r == 2) ? C2 : C3;
      localparam int EI = (c + SH) % NB;
      localparam int DI = (c - SH + NB) % NB;
      assign shf[c][31-8*r -: 8] = enc_dec_i ?
        state_i[EI][31-8*r -: 8] :
        state_i[DI][31-8*r -: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    valid_o = 1'b0;
    ready_o = 1'b1;
    ld_new  = 1'b0;
    ld_tail = 1'b0;
    mv_tail = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (valid_i) begin
          ld_new  = 1'b1;
          state_d = ONE;
        end
      end
      ONE: begin
        valid_o = 1'b1;
        unique case ({valid_i, ready_i})
          2'b10: begin
            ld_tail = 1'b1;
            state_d = FULL;
          end
          2'b01: state_d = EMPTY;
          2'b11: ld_new = 1'b1;
          default: ;
        endcase
      end
      FULL: begin
        valid_o = 1'b1;
        ready_o = 1'b0;
        if (ready_i) begin
          mv_tail = 1'b1;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign pop = valid_o && ready_i;

  // Head is left untouched on a pop to EMPTY so state_o keeps the last block.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= EMPTY;
      head_enc_q <= 1'b0;
      tail_enc_q <= 1'b0;
      for (int c = 0; c < NB; c++) begin
        head_q[c] <= '0;
        tail_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (ld_new) begin
        head_q     <= shf;
        head_enc_q <= enc_dec_i;
      end else if (mv_tail) begin
        head_q     <= tail_q;
        head_enc_q <= tail_enc_q;
      end
      if (ld_tail) begin
        tail_q     <= shf;
        tail_enc_q <= enc_dec_i;
      end
    end
  end

  assign state_o   = head_q;
  assign enc_dec_o = head_enc_q;

`ifdef RS_PIPE_STATS_EN
  logic [15:0] blk_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      blk_cnt_q <= '0;
    end else if (pop) begin
      blk_cnt_q <= blk_cnt_q + 16'd1;
    end
  end

  assign blk_cnt_o = blk_cnt_q;
`else
  logic unused_pop;
  assign unused_pop = pop;
`endif

endmodule

// File: tb/tb_rs_pipe.sv
// tb_rs_pipe: directed checks of rs_pipe at NB=4 and NB=8.
// Covers FIPS-197 round-1 ShiftRows, inverse, backpressure, streaming, reset.
module tb_rs_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v4, enc4, rdy_o4, vo4, rdy4, eo4;
  logic [31:0] st4 [3:0];
  logic [31:0] so4 [3:0];
  logic        v8, enc8, rdy_o8, vo8, rdy8, eo8;
  logic [31:0] st8 [7:0];
  logic [31:0] so8 [7:0];
`ifdef RS_PIPE_STATS_EN
  logic [15:0] cnt4, cnt8;
`endif

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] IN8 [8] = '{
    32'h00102030, 32'h01112131, 32'h02122232, 32'h03132333,
    32'h04142434, 32'h05152535, 32'h06162636, 32'h07172737};
  localparam logic [31:0] ENC8 [8] = '{
    32'h00112334, 32'h01122435, 32'h02132536, 32'h03142637,
    32'h04152730, 32'h05162031, 32'h06172132, 32'h07102233};

  rs_pipe #(.NB(4)) u4 (
    .clk_i(clk), .rst_i(rst),
    .valid_i(v4), .ready_o(rdy_o4),
    .enc_dec_i(enc4), .state_i(st4),
    .valid_o(vo4), .ready_i(rdy4),
    .enc_dec_o(eo4), .state_o(so4)
`ifdef RS_PIPE_STATS_EN
    , .blk_cnt_o(cnt4)
`endif
  );

  rs_pipe #(.NB(8)) u8 (
    .clk_i(clk), .rst_i(rst),
    .valid_i(v8), .ready_o(rdy_o8),
    .enc_dec_i(enc8), .state_i(st8),
    .valid_o(vo8), .ready_i(rdy8),
    .enc_dec_o(eo8), .state_o(so8)
`ifdef RS_PIPE_STATS_EN
    , .blk_cnt_o(cnt8)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set4(input logic [31:0] w0, w1, w2, w3);
    st4[0] = w0;
    st4[1] = w1;
    st4[2] = w2;
    st4[3] = w3;
  endtask

  initial begin
    rst = 1'b1;
    v4 = 1'b0; enc4 = 1'b0; rdy4 = 1'b1;
    v8 = 1'b0; enc8 = 1'b0; rdy8 = 1'b1;
    set4('0, '0, '0, '0);
    for (int c = 0; c < 8; c++) st8[c] = '0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_valid_o", 32'(vo4), 32'd0);
    chk("rst_ready_o", 32'(rdy_o4), 32'd1);
    chk("rst_enc_o", 32'(eo4), 32'd0);
    for (int c = 0; c < 4; c++) chk("rst_state_o", so4[c], 32'd0);

    // FIPS-197 App.B round 1
    set4(32'hd42711ae, 32'he0bf98f1, 32'hb8b45de5, 32'h1e415230);
    enc4 = 1'b1; v4 = 1'b1;
    tick();
    chk("fips_valid", 32'(vo4), 32'd1);
    chk("fips_enc", 32'(eo4), 32'd1);
    chk("fips_c0", so4[0], 32'hd4bf5d30);
    chk("fips_c1", so4[1], 32'he0b452ae);
    chk("fips_c2", so4[2], 32'hb84111f1);
    chk("fips_c3", so4[3], 32'h1e2798e5);

    set4(32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5);
    enc4 = 1'b0;
    tick();
    chk("inv_valid", 32'(vo4), 32'd1);
    chk("inv_enc", 32'(eo4), 32'd0);
    chk("inv_c0", so4[0], 32'hd42711ae);
    chk("inv_c1", so4[1], 32'he0bf98f1);
    chk("inv_c2", so4[2], 32'hb8b45de5);
    chk("inv_c3", so4[3], 32'h1e415230);
    v4 = 1'b0;
    tick();
    chk("drain_valid", 32'(vo4), 32'd0);
    chk("hold_last_c0", so4[0], 32'hd42711ae);

    // Backpressure: A, B fill the buffer, C waits
    rdy4 = 1'b0;
    set4(32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff);
    enc4 = 1'b1; v4 = 1'b1;
    tick();
    chk("bp_a_ready", 32'(rdy_o4), 32'd1);
    enc4 = 1'b0;
    tick();
    chk("bp_full_ready", 32'(rdy_o4), 32'd0);
    set4(32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210);
    enc4 = 1'b1;
    tick();
    chk("bp_held_ready", 32'(rdy_o4), 32'd0);
    chk("bp_head_a", so4[0], 32'h0055aaff);
    rdy4 = 1'b1;
    #1;
    chk("bp_a_valid", 32'(vo4), 32'd1);
    chk("bp_a_out", so4[0], 32'h0055aaff);
    chk("bp_a_enc", 32'(eo4), 32'd1);
    tick();
    chk("bp_b_valid", 32'(vo4), 32'd1);
    chk("bp_b_out", so4[0], 32'h00ddaa77);
    chk("bp_b_enc", 32'(eo4), 32'd0);
    tick();
    v4 = 1'b0;
    chk("bp_c_valid", 32'(vo4), 32'd1);
    chk("bp_c_out", so4[0], 32'h01abba10);
    chk("bp_c_enc", 32'(eo4), 32'd1);
    tick();
    chk("bp_empty", 32'(vo4), 32'd0);

    // NB=8 encrypt then decrypt
    for (int c = 0; c < 8; c++) st8[c] = IN8[c];
    enc8 = 1'b1; v8 = 1'b1;
    tick();
    v8 = 1'b0;
    chk("nb8_valid", 32'(vo8), 32'd1);
    chk("nb8_col0", so8[0], 32'h00112334);
    chk("nb8_col7", so8[7], 32'h07102233);
    for (int c = 0; c < 8; c++) chk("nb8_enc", so8[c], ENC8[c]);
    tick();
    for (int c = 0; c < 8; c++) st8[c] = ENC8[c];
    enc8 = 1'b0; v8 = 1'b1;
    tick();
    v8 = 1'b0;
    chk("nb8_dvalid", 32'(vo8), 32'd1);
    chk("nb8_denc", 32'(eo8), 32'd0);
    for (int c = 0; c < 8; c++) chk("nb8_dec", so8[c], IN8[c]);
    tick();

    // Streaming 16 blocks
    rst = 1'b1;
    tick();
    rst = 1'b0;
    enc4 = 1'b1; v4 = 1'b1; rdy4 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set4({4{8'(i)}}, {4{8'(i)}}, {4{8'(i)}}, {4{8'(i)}});
      tick();
      chk("str_valid", 32'(vo4), 32'd1);
      chk("str_data", so4[0], {4{8'(i)}});
    end
    v4 = 1'b0;
    tick();
    chk("str_end", 32'(vo4), 32'd0);
`ifdef RS_PIPE_STATS_EN
    chk("cnt_16", 32'(cnt4), 32'd16);
    v4 = 1'b1;
    repeat (65519) tick();
    v4 = 1'b0;
    tick();
    chk("cnt_ffff", 32'(cnt4), 32'h0000ffff);
    v4 = 1'b1;
    tick();
    v4 = 1'b0;
    tick();
    chk("cnt_wrap", 32'(cnt4), 32'd0);
`endif

    // Reset while FULL
    rdy4 = 1'b0;
    set4(32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff);
    enc4 = 1'b1; v4 = 1'b1;
    tick();
    tick();
    chk("rf_full", 32'(rdy_o4), 32'd0);
    rst = 1'b1;
    set4(32'hdeadbeef, 32'hdeadbeef, 32'hdeadbeef, 32'hdeadbeef);
    tick();
    rst = 1'b0;
    v4 = 1'b0;
    chk("rf_valid", 32'(vo4), 32'd0);
    chk("rf_ready", 32'(rdy_o4), 32'd1);
    chk("rf_enc", 32'(eo4), 32'd0);
    for (int c = 0; c < 4; c++) chk("rf_state", so4[c], 32'd0);
    set4(32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff);
    v4 = 1'b1;
    tick();
    v4 = 1'b0;
    chk("rf_push_valid", 32'(vo4), 32'd1);
    chk("rf_push_ready", 32'(rdy_o4), 32'd1);
    chk("rf_push_data", so4[0], 32'h0055aaff);
    rdy4 = 1'b1;
    tick();
    chk("rf_pop", 32'(vo4), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rs_pipe.md
Name: rs_pipe

Overview:
- Parametrised, registered successor of the combinational ShiftRows/InvShiftRows unit in the cipher datapath.
- Supports the Rijndael block widths Nb = 4, 6 and 8 columns, selected by parameter.
- Moves data with valid/ready handshakes and a 2-entry output buffer, so it sits between SubBytes and MixColumns without combinational backpressure paths.
- Encrypt/decrypt direction is carried per block.

Parameters:
- NB, 4: number of 32-bit state columns. Only 4, 6 or 8 are legal; any other value is an elaboration-time error.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high, sampled on rising clk_i
- valid_i  in  1  input block valid
- ready_o  out  1  block can accept input
- enc_dec_i  in  1  1 = encrypt (ShiftRows), 0 = decrypt (InvShiftRows); sampled with the block
- state_i  in  32 x NB (unpacked [NB-1:0])  input state; index c = column c; byte [31:24] = row 0, [23:16] = row 1, [15:8] = row 2, [7:0] = row 3
- valid_o  out  1  output block valid
- ready_i  in  1  downstream accepts
- enc_dec_o  out  1  direction tag of the output block
- state_o  out  32 x NB  shifted state, same layout as state_i

Behaviour:
- Row offsets C1/C2/C3:
  - NB=4: 1,2,3
  - NB=6: 1,2,3
  - NB=8: 1,3,4
  - Row 0 is never shifted.
- Encrypt: out[c].row r = in[(c + Cr) mod NB].row r.
- Decrypt: out[c].row r = in[(c − Cr + NB) mod NB].row r.
- Shift is applied combinationally at the input. The result plus its direction tag is written into a 2-entry FIFO.
- Handshake:
  - Push when valid_i && ready_o.
  - Pop when valid_o && ready_i.
  - Senders must hold state_i/enc_dec_i stable while valid_i && !ready_o.
- State machine on occupancy:
  - EMPTY: valid_o=0, ready_o=1. Push → ONE.
  - ONE: valid_o=1, ready_o=1.
    - Push only → FULL.
    - Pop only → EMPTY.
    - Push and pop in the same cycle → ONE, head replaced by the new block.
  - FULL: valid_o=1, ready_o=0. Pop → ONE. valid_i is ignored.
- Latency: 1 cycle from accepted input to valid_o. Throughput: 1 block/cycle while ready_i=1.
- ready_o is a function of registered state only; no combinational path from ready_i or valid_i.
- state_o/enc_dec_o always present the FIFO head. They are stable while valid_o && !ready_i.
- Ordering is strictly FIFO. No block is dropped or duplicated.
- Reset, including mid-transfer:
  - Next edge → EMPTY.
  - valid_o=0, ready_o=1, enc_dec_o=0, state_o all zero; both storage entries zeroed.
  - Inputs presented in the reset cycle are discarded.
- Output while EMPTY: state_o holds the last popped value. After reset it is zero.

Optional Feature:
- Macro: RS_PIPE_STATS_EN.
- Defined: adds output blk_cnt_o [15:0].
  - Increments on every pop and wraps 0xFFFF → 0x0000.
  - Cleared by rst_i.
  - Push and pop in the same cycle increments once.
- Undefined: the port and counter do not exist. Core behaviour is identical.

Test Plan:
- FIPS-197 App.B round 1, NB=4, enc_dec_i=1, ready_i=1:
  - state_i = {d42711ae, e0bf98f1, b8b45de5, 1e415230} (col0..3)
  - → one cycle later state_o = {d4bf5d30, e0b452ae, b84111f1, 1e2798e5}, enc_dec_o=1.
- Same output vector fed back with enc_dec_i=0 → state_o = original {d42711ae, e0bf98f1, b8b45de5, 1e415230}. Inverse check.
- NB=8, state_i[c] = {8'h0c, 8'h1c, 8'h2c, 8'h3c} (c=0..7), encrypt:
  - → out col0 = 00_11_23_34
  - → out col7 = 07_10_22_33
  - Decrypt of the result restores the input.
- Backpressure:
  - ready_i=0, push blocks A, B → ready_o=0 after B; block C held.
  - Raise ready_i → A, B, C emerge in order on consecutive cycles, none lost.
- Streaming with ready_i=1 and valid_i=1 for 16 cycles → 16 outputs in 16 consecutive cycles after a 1-cycle latency.
  - With RS_PIPE_STATS_EN: blk_cnt_o=16.
  - Preload the counter path to 0xFFFF → wraps to 0.
- Assert rst_i while FULL with ready_i=0 → next cycle valid_o=0, ready_o=1, state_o=0, enc_dec_o=0. Subsequent push behaves as from EMPTY.
